// File: rtl/matrix_key_scan_if.sv
// ============================================================================
// Module      : matrix_key_scan_if
// Description : Keypad-side and key-event signals of the matrix key scanner.
//               master : the scanner (drives rows and key outputs, reads cols)
//               slave  : the keypad / consumer side
//   col_n       [3:0] keypad columns, active-low, pulled up, asynchronous
//   row_n       [3:0] keypad row drive, one-hot-low
//   key_code    [3:0] last accepted key, row*4+col
//   key_valid         one-clk pulse on accepted press
//   key_pressed       level, high from acceptance until debounced release
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface matrix_key_scan_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_pressed
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_pressed
  );
endinterface

`default_nettype wire

// File: rtl/matrix_key_scan.sv
// ============================================================================
// Module      : matrix_key_scan
// Description : 4x4 keypad scanner with press/release debounce.
//               Drives one row low at a time, samples the synchronized
//               columns on every scan tick, debounces a press for DB_TICKS
//               ticks, reports it once, then waits for a debounced release.
// Ports       : clk          system clock (posedge)
//               rst_n        asynchronous active-low reset
//               kp (master)  col_n in; row_n, key_code, key_valid,
//                            key_pressed out
// Parameters  : F_CLK    system clock frequency in Hz
//               F_SCAN   scan tick rate in Hz
//               DB_TICKS consecutive stable ticks for press/release debounce
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module matrix_key_scan #(
  parameter int F_CLK    = 50000000,
  parameter int F_SCAN   = 1000,
  parameter int DB_TICKS = 20
) (
  input wire              clk,
  input wire              rst_n,
  matrix_key_scan_if.master kp
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int TICK_DIV = F_CLK / F_SCAN;
  // A divide-by-one still needs a 1-bit counter to keep the logic legal.
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam int DB_W = $clog2(DB_TICKS + 1);
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DB_TICKS);
  localparam logic [DB_W-1:0] DB_MAX    = {DB_W{1'b1}};

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        sync2_q, sync2_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  state_t            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]        row_n_q, row_n_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_pressed_q, key_pressed_d;

  // Combinational helpers
  logic              tick;
  logic [1:0]        first_low;
  logic              col_c_high;
  logic [DB_W-1:0]   db_inc;

  // --------------------------------------------------------------------------
  // Column synchronizer: col_n is asynchronous and bouncy, so nothing below
  // ever looks at it before two flop stages.
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d = kp.col_n;
    sync2_d = sync1_q;
  end

  // --------------------------------------------------------------------------
  // Scan tick: one-clk strobe on the last count of each period, so the first
  // tick after reset lands exactly TICK_DIV clocks later.
  // --------------------------------------------------------------------------
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Lowest-index low column wins when several keys on a row are down.
  always_comb begin
    first_low = 2'd3;
    if      (!sync2_q[0]) first_low = 2'd0;
    else if (!sync2_q[1]) first_low = 2'd1;
    else if (!sync2_q[2]) first_low = 2'd2;
  end

  always_comb begin
    col_c_high = sync2_q[col_idx_q];
    // Saturating increment: the counter never wraps back to zero.
    db_inc     = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Scan / debounce state machine (evaluated on tick cycles only)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_idx_d     = col_idx_q;
    db_cnt_d      = db_cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;

    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (sync2_q != 4'hF) begin
            // Row stays put; the latched row/column identify the key.
            col_idx_d = first_low;
            db_cnt_d  = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (!col_c_high) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_TARGET) begin
              key_code_d    = {row_q, col_idx_q};
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              state_d       = ST_HOLD;
            end
          end else begin
            // Glitch: abandon this candidate and move on to the next row.
            row_d   = row_q + 1'b1;
            state_d = ST_SCAN;
          end
        end

        ST_HOLD: begin
          // Only the accepted column matters; extra keys are ignored.
          if (col_c_high) begin
            db_cnt_d = '0;
            state_d  = ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (col_c_high) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_TARGET) begin
              key_pressed_d = 1'b0;
              row_d         = row_q + 1'b1;
              state_d       = ST_SCAN;
            end
          end else begin
            // Release bounce: still the same press, so no new key_valid.
            state_d = ST_HOLD;
          end
        end

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  // Row drive is registered alongside the row index to keep it glitch-free.
  always_comb begin
    row_n_d = ~(4'b0001 << row_d);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 4'b1111;
      sync2_q       <= 4'b1111;
      tick_cnt_q    <= '0;
      state_q       <= ST_SCAN;
      row_q         <= 2'd0;
      col_idx_q     <= 2'd0;
      db_cnt_q      <= '0;
      row_n_q       <= 4'b1110;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      tick_cnt_q    <= tick_cnt_d;
      state_q       <= state_d;
      row_q         <= row_d;
      col_idx_q     <= col_idx_d;
      db_cnt_q      <= db_cnt_d;
      row_n_q       <= row_n_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign kp.row_n       = row_n_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_pressed = key_pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_key_scan.sv
// ============================================================================
// Module      : tb_matrix_key_scan
// Description : Self-checking bench for matrix_key_scan. A keypad model turns
//               a 16-bit "keys held" vector into column levels based on the
//               row being driven; expectations come from the scan-tick
//               timeline (tick every 10 clk, 3-tick debounce).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_matrix_key_scan;

  localparam int TICK = 10;
  localparam int DB   = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys  = '0;
  logic [3:0]  col_drv;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int valid_cnt = 0;

  matrix_key_scan_if bus();

  matrix_key_scan #(
    .F_CLK    (1000),
    .F_SCAN   (100),
    .DB_TICKS (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (bus)
  );

  always #5 clk = ~clk;

  // Keypad: a held key at (r,c) pulls column c low while row r is driven.
  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !bus.row_n[r]) col_drv[c] = 1'b0;
  end
  assign bus.col_n = col_drv;

  // Clocks since reset release; scan ticks land when cyc is a multiple of TICK.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && bus.key_valid === 1'b1) valid_cnt++;
  end

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (r % 4));
  endfunction

  // Waits until row_n switches to target; returns just after that tick edge.
  task automatic wait_row(input logic [3:0] target);
    int n;
    n = 0;
    while (bus.row_n === target && n < 100) begin
      @(posedge clk); #1; n++;
    end
    while (bus.row_n !== target && n < 200) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (bus.row_n !== target) begin
      n_fail++;
      $display("FAIL wait_row: row_n=%b never became %b", bus.row_n, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.row_n !== 4'b1110) begin n_fail++; $display("FAIL reset_row_n: got %b want 1110", bus.row_n); end
    n_checks++;
    if (bus.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h want 0", bus.key_code); end
    n_checks++;
    if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", bus.key_valid); end
    n_checks++;
    if (bus.key_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_key_pressed: got %b want 0", bus.key_pressed); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Rows step every TICK clocks from reset release; first step at cyc==TICK.
  task automatic test_idle_scan();
    int v0;
    logic [3:0] exp;
    v0 = valid_cnt;
    for (int k = 1; k <= 8 * TICK; k++) begin
      @(posedge clk); #1;
      exp = row_pat(cyc / TICK);
      n_checks++;
      if (bus.row_n !== exp) begin
        n_fail++;
        $display("FAIL idle_row_n: clk %0d got %b want %b", cyc, bus.row_n, exp);
      end
    end
    n_checks++;
    if (valid_cnt !== v0) begin n_fail++; $display("FAIL idle_no_valid: got %0d pulses want 0", valid_cnt - v0); end
  endtask

  task automatic test_clean_press();
    int v0;
    v0 = valid_cnt;
    wait_row(4'b1011);
    keys[10] = 1'b1;               // row 2, col 2
    repeat (DB * TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_pressed !== 1'b0 || valid_cnt !== v0) begin
      n_fail++;
      $display("FAIL press_early: pressed=%b pulses=%0d want 0/0", bus.key_pressed, valid_cnt - v0);
    end
    repeat (TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid: got %b want 1", bus.key_valid); end
    n_checks++;
    if (bus.key_code !== 4'hA) begin n_fail++; $display("FAIL press_code: got %h want a", bus.key_code); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL press_pulse_width: got %b want 0", bus.key_valid); end
    repeat (TICK - 1) @(posedge clk);
    repeat (TICK) @(posedge clk);
    #1;
    n_checks++;
    if (valid_cnt - v0 !== 1 || bus.key_pressed !== 1'b1) begin
      n_fail++;
      $display("FAIL press_hold: pulses=%0d pressed=%b want 1/1", valid_cnt - v0, bus.key_pressed);
    end
    // Now tick-aligned: release; one tick to notice, then DB ticks of debounce.
    keys[10] = 1'b0;
    repeat (DB * TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_pressed !== 1'b1) begin n_fail++; $display("FAIL release_early: pressed=%b want 1", bus.key_pressed); end
    repeat (TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_pressed !== 1'b0) begin n_fail++; $display("FAIL release_pressed: got %b want 0", bus.key_pressed); end
    n_checks++;
    if (bus.row_n !== 4'b0111) begin n_fail++; $display("FAIL release_row_n: got %b want 0111", bus.row_n); end
    n_checks++;
    if (bus.key_code !== 4'hA) begin n_fail++; $display("FAIL release_code_kept: got %h want a", bus.key_code); end
  endtask

  task automatic test_bounce();
    int v0;
    v0 = valid_cnt;
    wait_row(4'b1110);
    keys[1] = 1'b1;                // row 0, col 1 for one tick only
    repeat (TICK) @(posedge clk);
    #1;
    keys[1] = 1'b0;
    repeat (TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.row_n !== 4'b1101) begin n_fail++; $display("FAIL bounce_row_n: got %b want 1101", bus.row_n); end
    repeat (2 * TICK) @(posedge clk);
    #1;
    n_checks++;
    if (valid_cnt !== v0 || bus.key_pressed !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_no_key: pulses=%0d pressed=%b want 0/0", valid_cnt - v0, bus.key_pressed);
    end
  endtask

  task automatic test_multi_key();
    int v0;
    v0 = valid_cnt;
    wait_row(4'b1110);
    keys[1] = 1'b1;                // col_n = 0101 on row 0
    keys[3] = 1'b1;
    repeat (6 * TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_code !== 4'h1 || valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL multi_key: code=%h pulses=%0d want 1/1", bus.key_code, valid_cnt - v0);
    end
    keys = '0;
    repeat (6 * TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_pressed !== 1'b0) begin n_fail++; $display("FAIL multi_release: pressed=%b want 0", bus.key_pressed); end
  endtask

  task automatic test_release_bounce();
    int v0;
    int drops;
    v0 = valid_cnt;
    drops = 0;
    wait_row(4'b1101);
    keys[5] = 1'b1;                // row 1, col 1
    repeat (6 * TICK) @(posedge clk);
    #1;
    keys[5] = 1'b0;                // tick-aligned: drop for one tick
    repeat (TICK) @(posedge clk);
    #1;
    keys[5] = 1'b1;
    for (int k = 0; k < 4 * TICK; k++) begin
      @(posedge clk); #1;
      if (bus.key_pressed !== 1'b1) drops++;
    end
    n_checks++;
    if (drops !== 0) begin n_fail++; $display("FAIL rel_bounce_level: pressed low for %0d clk want 0", drops); end
    n_checks++;
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rel_bounce_pulses: got %0d want 1", valid_cnt - v0); end
    keys = '0;
    repeat (6 * TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_pressed !== 1'b0 || valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL rel_bounce_end: pressed=%b pulses=%0d want 0/1", bus.key_pressed, valid_cnt - v0);
    end
  endtask

  task automatic test_reset_mid_hold();
    int v0;
    v0 = valid_cnt;
    wait_row(4'b1011);
    keys[8] = 1'b1;                // row 2, col 0
    repeat (5 * TICK) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_pressed !== 1'b1 || bus.key_code !== 4'h8) begin
      n_fail++;
      $display("FAIL hold_before_reset: pressed=%b code=%h want 1/8", bus.key_pressed, bus.key_code);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.row_n !== 4'b1110 || bus.key_code !== 4'h0 || bus.key_valid !== 1'b0 || bus.key_pressed !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: row_n=%b code=%h valid=%b pressed=%b want 1110/0/0/0",
               bus.row_n, bus.key_code, bus.key_valid, bus.key_pressed);
    end
    repeat (2) @(posedge clk);
    #1;
    keys = '0;
    rst_n = 1'b1;
    repeat (TICK - 1) @(posedge clk);
    #1;
    n_checks++;
    if (bus.row_n !== 4'b1110) begin n_fail++; $display("FAIL post_reset_row0: got %b want 1110", bus.row_n); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.row_n !== 4'b1101) begin n_fail++; $display("FAIL post_reset_row1: got %b want 1101", bus.row_n); end
    n_checks++;
    if (valid_cnt - v0 !== 1 || bus.key_pressed !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_state: pulses=%0d pressed=%b want 1/0", valid_cnt - v0, bus.key_pressed);
    end
  endtask

  // Random row and set of held columns; the lowest held column wins.
  task automatic test_random();
    int v0, row, lowc;
    logic [3:0] mask;
    logic [3:0] exp_code;
    for (int it = 0; it < 8; it++) begin
      row  = $urandom_range(0, 3);
      mask = 4'($urandom_range(1, 15));
      lowc = 0;
      while (!mask[lowc]) lowc++;
      exp_code = 4'(row * 4 + lowc);
      v0 = valid_cnt;
      repeat ($urandom_range(0, 15)) @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) keys[row*4+c] = mask[c];
      repeat (10 * TICK) @(posedge clk);
      #1;
      n_checks++;
      if (valid_cnt - v0 !== 1 || bus.key_code !== exp_code || bus.key_pressed !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_press[%0d]: pulses=%0d code=%h pressed=%b want 1/%h/1",
                 it, valid_cnt - v0, bus.key_code, bus.key_pressed, exp_code);
      end
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
      keys = '0;
      repeat (6 * TICK) @(posedge clk);
      #1;
      n_checks++;
      if (bus.key_pressed !== 1'b0 || valid_cnt - v0 !== 1 || bus.key_code !== exp_code) begin
        n_fail++;
        $display("FAIL rand_release[%0d]: pressed=%b pulses=%0d code=%h want 0/1/%h",
                 it, bus.key_pressed, valid_cnt - v0, bus.key_code, exp_code);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_release_bounce();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
